// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle shared by the MEM stage (C), the UART engine (U) and the data memory,
// as seen around dmem_bus_arbiter.
interface dmem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_read;
    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_stall;
    logic              u_req;
    logic              u_write;
    logic [ADDR_W-1:0] u_addr;
    logic [DATA_W-1:0] u_wdata;
    logic              u_gnt;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata;

    modport slave (
        input  c_read, c_write, c_addr, c_wdata,
        input  u_req, u_write, u_addr, u_wdata,
        input  mem_rdata,
        output c_stall, u_gnt,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output rdata
    );

    modport master (
        output c_read, c_write, c_addr, c_wdata,
        output u_req, u_write, u_addr, u_wdata,
        output mem_rdata,
        input  c_stall, u_gnt,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  rdata
    );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Two-owner arbiter for the data-memory bus: MEM stage (C) vs UART engine (U), with
// bounded U starvation and bounded U bursts. Define ARB_STATS_EN for the stall counter.
module dmem_bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_bus_arbiter_if.slave bus,
    output logic [15:0]       stall_cnt
);
    localparam int WAIT_W  = $clog2(MAX_WAIT) + 1;
    localparam int BURST_W = $clog2(BURST_MAX) + 1;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_U = 1'b1
    } state_t;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;

    logic              c_act;
    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              gnt;
    logic              c_stall_i;

    assign c_act = bus.c_read | bus.c_write;

    // Bus steering follows the registered owner with no added latency; reset silences both strobes.
    always_comb begin
        sel_read  = bus.c_read;
        sel_write = bus.c_write;
        sel_addr  = bus.c_addr;
        sel_wdata = bus.c_wdata;
        gnt       = 1'b0;
        c_stall_i = 1'b0;
        if (state == OWN_U) begin
            sel_read  = bus.u_req & ~bus.u_write;
            sel_write = bus.u_req & bus.u_write;
            sel_addr  = bus.u_addr;
            sel_wdata = bus.u_wdata;
            gnt       = bus.u_req;
            c_stall_i = c_act;
        end
        if (!rst_n) begin
            sel_read  = 1'b0;
            sel_write = 1'b0;
            gnt       = 1'b0;
            c_stall_i = 1'b0;
        end
    end

    assign bus.mem_read  = sel_read;
    assign bus.mem_write = sel_write;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.u_gnt     = gnt;
    assign bus.c_stall   = c_stall_i;
    assign bus.rdata     = bus.mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OWN_C;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                OWN_C: begin
                    if (bus.u_req) begin
                        if (!c_act || wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                            state    <= OWN_U;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                OWN_U: begin
                    // A dropped request costs one idle bus cycle before C gets the bus back.
                    if (bus.u_req) begin
                        if (burst_cnt == BURST_W'(BURST_MAX - 1)) begin
                            state     <= OWN_C;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        end
                    end else begin
                        state     <= OWN_C;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state     <= OWN_C;
                    wait_cnt  <= '0;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (c_stall_i && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
